// File: rtl/cla_pkg.sv
// cla_pkg: shared definitions for the pipelined carry-lookahead adder.
//   CLA_GROUP_DEFAULT : default number of bits per lookahead group
//   gp_t              : group generate/propagate pair
//   cla_nstg()        : pipeline stage count for a given width and group size
package cla_pkg;

  localparam int CLA_GROUP_DEFAULT = 8;

  typedef struct packed {
    logic g;
    logic p;
  } gp_t;

  // One pipeline stage per lookahead group.
  function automatic int cla_nstg(input int width, input int group);
    return width / group;
  endfunction

endpackage

// File: rtl/cla_group.sv
// cla_group: combinational GROUP-bit carry-lookahead adder.
// Ports:
//   x, y : GROUP-bit operand slices
//   cin  : carry into bit 0 of the slice
//   sum  : GROUP-bit sum slice
//   g    : group generate (slice produces a carry regardless of cin)
//   p    : group propagate (slice passes cin straight through)
// Every internal carry is a flat OR of AND terms over the bit-level g/p
// signals; no carry is derived from a neighbouring bit's carry.
module cla_group
  import cla_pkg::*;
#(
  parameter int GROUP = CLA_GROUP_DEFAULT
) (
  input  logic [GROUP-1:0] x,
  input  logic [GROUP-1:0] y,
  input  logic             cin,
  output logic [GROUP-1:0] sum,
  output logic             g,
  output logic             p
);

  logic [GROUP-1:0] bg_s;
  logic [GROUP-1:0] bp_s;
  logic [GROUP-1:0] c_s;

  assign bg_s = x & y;
  assign bp_s = x ^ y;

  // Sum-of-products carries: carry into bit i+1 is any generate at j<=i
  // propagated through bits j+1..i, or cin propagated through bits 0..i.
  always_comb begin
    logic gen_s;
    logic term_s;
    logic prop_s;
    c_s    = {GROUP{1'b0}};
    g      = 1'b0;
    gen_s  = 1'b0;
    term_s = 1'b0;
    prop_s = 1'b0;
    c_s[0] = cin;
    for (int i = 0; i < GROUP; i++) begin
      gen_s = 1'b0;
      for (int j = 0; j <= i; j++) begin
        term_s = bg_s[j];
        for (int m = j + 1; m <= i; m++) begin
          term_s = term_s & bp_s[m];
        end
        gen_s = gen_s | term_s;
      end
      prop_s = cin;
      for (int m = 0; m <= i; m++) begin
        prop_s = prop_s & bp_s[m];
      end
      if (i < GROUP - 1) begin
        c_s[i+1] = gen_s | prop_s;
      end else begin
        g = gen_s;
      end
    end
  end

  assign p   = &bp_s;
  assign sum = bp_s ^ c_s;

endmodule

// File: rtl/cla_pipe_adder.sv
// cla_pipe_adder: WIDTH-bit modular adder pipelined one lookahead group per
// stage (NSTG = WIDTH/GROUP stages), with valid/ready handshakes.
// Ports:
//   clock, reset        : rising-edge clock, synchronous active-high reset
//   in_valid/in_ready   : operand handshake; in_ready = !stall and low in reset
//   in_x, in_y, in_cin  : operands and carry-in
//   out_valid/out_ready : result handshake
//   out_sum             : (in_x + in_y + in_cin) mod 2^WIDTH
//   out_cout            : final carry, only when CLA_PIPE_COUT_EN is defined
// Stage k adds slice k; upper operand slices and finished lower sum slices
// ride along in per-stage skew registers. A stall freezes the whole pipe.
module cla_pipe_adder
  import cla_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int GROUP = CLA_GROUP_DEFAULT
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_x,
  input  logic [WIDTH-1:0] in_y,
  input  logic             in_cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum
`ifdef CLA_PIPE_COUT_EN
  ,
  output logic             out_cout
`endif
);

  localparam int NSTG = cla_nstg(WIDTH, GROUP);

  logic stall_s;

  for (genvar k = 0; k < NSTG; k++) begin : g_stage
    localparam int RW = WIDTH - k * GROUP;  // operand bits not yet added
    localparam int SW = (k + 1) * GROUP;    // sum bits complete after stage k

    logic [RW-1:0]    xs_s;
    logic [RW-1:0]    ys_s;
    logic             cs_s;
    logic             vin_s;
    logic [GROUP-1:0] gsum_s;
    logic [SW-1:0]    nsum_s;
    logic             gcout_s;
    gp_t              gp_s;
    logic             valid_r;
    logic [SW-1:0]    sum_r;

    if (k == 0) begin : g_head
      assign xs_s   = in_x;
      assign ys_s   = in_y;
      assign cs_s   = in_cin;
      assign vin_s  = in_valid;
      assign nsum_s = gsum_s;
    end else begin : g_body
      assign xs_s   = g_stage[k-1].g_fwd.x_r;
      assign ys_s   = g_stage[k-1].g_fwd.y_r;
      assign cs_s   = g_stage[k-1].g_fwd.carry_r;
      assign vin_s  = g_stage[k-1].valid_r;
      assign nsum_s = {gsum_s, g_stage[k-1].sum_r};
    end

    cla_group #(.GROUP(GROUP)) u_group (
      .x   (xs_s[GROUP-1:0]),
      .y   (ys_s[GROUP-1:0]),
      .cin (cs_s),
      .sum (gsum_s),
      .g   (gp_s.g),
      .p   (gp_s.p)
    );

    // Group-level lookahead: carry out of this slice.
    assign gcout_s = gp_s.g | (gp_s.p & cs_s);

    // Stage valid bit and accumulated sum slices.
    always_ff @(posedge clock) begin
      if (reset) begin
        valid_r <= 1'b0;
        sum_r   <= {SW{1'b0}};
      end else if (!stall_s) begin
        valid_r <= vin_s;
        sum_r   <= nsum_s;
      end else begin
        valid_r <= valid_r;
        sum_r   <= sum_r;
      end
    end

    if (k < NSTG - 1) begin : g_fwd
      logic [RW-GROUP-1:0] x_r;
      logic [RW-GROUP-1:0] y_r;
      logic                carry_r;

      // Skewed upper operand slices and the carry into the next stage.
      always_ff @(posedge clock) begin
        if (reset) begin
          x_r     <= {(RW-GROUP){1'b0}};
          y_r     <= {(RW-GROUP){1'b0}};
          carry_r <= 1'b0;
        end else if (!stall_s) begin
          x_r     <= xs_s[RW-1:GROUP];
          y_r     <= ys_s[RW-1:GROUP];
          carry_r <= gcout_s;
        end else begin
          x_r     <= x_r;
          y_r     <= y_r;
          carry_r <= carry_r;
        end
      end
    end else begin : g_last
`ifdef CLA_PIPE_COUT_EN
      logic cout_r;

      // Final carry, aligned with the last stage's sum.
      always_ff @(posedge clock) begin
        if (reset) begin
          cout_r <= 1'b0;
        end else if (!stall_s) begin
          cout_r <= gcout_s;
        end else begin
          cout_r <= cout_r;
        end
      end
`else
      // Modular sum only: the final carry is intentionally dropped.
      logic unused_cout_s;
      assign unused_cout_s = gcout_s;
`endif
    end
  end

  assign stall_s   = out_valid & ~out_ready;
  assign in_ready  = ~reset & ~stall_s;
  assign out_valid = g_stage[NSTG-1].valid_r;
  assign out_sum   = g_stage[NSTG-1].sum_r;
`ifdef CLA_PIPE_COUT_EN
  assign out_cout  = g_stage[NSTG-1].g_last.cout_r;
`endif

endmodule

// File: tb/tb_cla_pipe_adder.sv
// tb_cla_pipe_adder: self-checking bench for cla_pipe_adder.
// Main instance WIDTH=32/GROUP=8 plus two sweep instances (64/16, 16/8).
// Expected results come from a plain-arithmetic reference kept in a queue.
// Honours CLA_PIPE_COUT_EN for the optional out_cout port.
module tb_cla_pipe_adder;

  logic        clock;
  logic        reset;
  logic        in_valid, in_ready, in_cin, out_valid, out_ready;
  logic [31:0] in_x, in_y, out_sum;
`ifdef CLA_PIPE_COUT_EN
  logic        out_cout, s64_out_cout, s16_out_cout;
`endif
  logic        s64_in_valid, s64_in_ready, s64_out_valid;
  logic [63:0] s64_x, s64_sum;
  logic        s16_in_valid, s16_in_ready, s16_out_valid;
  logic [15:0] s16_x, s16_sum;

  int compared = 0;
  int mismatched = 0;
  int cyc = 0, nout = 0, first_out_cyc = 0, last_out_cyc = 0, last_lat = 0;
  logic [31:0] last_sum, prev_sum;
  logic        last_cout, prev_cout, last_acc, prev_stall;
  logic [32:0] expq[$];
  int          accq[$];
  logic [31:0] bx[8], by[8];
  logic        bc[8];
  int          sent, lat64, lat16;

  cla_pipe_adder u_dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_x(in_x), .in_y(in_y), .in_cin(in_cin),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum)
`ifdef CLA_PIPE_COUT_EN
    , .out_cout(out_cout)
`endif
  );

  cla_pipe_adder #(.WIDTH(64), .GROUP(16)) u_s64 (
    .clock(clock), .reset(reset),
    .in_valid(s64_in_valid), .in_ready(s64_in_ready),
    .in_x(s64_x), .in_y(s64_x), .in_cin(1'b0),
    .out_valid(s64_out_valid), .out_ready(1'b1), .out_sum(s64_sum)
`ifdef CLA_PIPE_COUT_EN
    , .out_cout(s64_out_cout)
`endif
  );

  cla_pipe_adder #(.WIDTH(16), .GROUP(8)) u_s16 (
    .clock(clock), .reset(reset),
    .in_valid(s16_in_valid), .in_ready(s16_in_ready),
    .in_x(s16_x), .in_y(s16_x), .in_cin(1'b0),
    .out_valid(s16_out_valid), .out_ready(1'b1), .out_sum(s16_sum)
`ifdef CLA_PIPE_COUT_EN
    , .out_cout(s16_out_cout)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [32:0] ref_add(input logic [31:0] a, input logic [31:0] b,
                                          input logic c);
    logic [63:0] t;
    t = {32'd0, a} + {32'd0, b} + {63'd0, c};
    return t[32:0];
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: sample/check before the rising edge, update the model.
  task automatic tick();
    logic [32:0] e;
    #1;
    if (reset) begin
      expq.delete();
      accq.delete();
      prev_stall = 1'b0;
      last_acc = 1'b0;
    end else begin
      check("in_ready", 64'(in_ready), 64'(!(out_valid && !out_ready)));
      if (prev_stall) begin
        check("hold_valid", 64'(out_valid), 64'd1);
        check("hold_sum", 64'(out_sum), 64'(prev_sum));
`ifdef CLA_PIPE_COUT_EN
        check("hold_cout", 64'(out_cout), 64'(prev_cout));
`endif
      end
      if (out_valid === 1'b1 && out_ready) begin
        check("queue_depth_at_out", 64'(expq.size() != 0), 64'd1);
        if (expq.size() != 0) begin
          e = expq.pop_front();
          last_lat = cyc - accq.pop_front();
          check("sum", 64'(out_sum), 64'(e[31:0]));
`ifdef CLA_PIPE_COUT_EN
          check("cout", 64'(out_cout), 64'(e[32]));
          last_cout = out_cout;
`endif
        end
        if (nout == 0) first_out_cyc = cyc;
        last_out_cyc = cyc;
        last_sum = out_sum;
        nout++;
      end
      last_acc = in_valid && in_ready;
      if (last_acc) begin
        expq.push_back(ref_add(in_x, in_y, in_cin));
        accq.push_back(cyc);
      end
      prev_stall = out_valid && !out_ready;
      prev_sum = out_sum;
`ifdef CLA_PIPE_COUT_EN
      prev_cout = out_cout;
`endif
    end
    cyc++;
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic drain(input int budget);
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < budget && expq.size() > 0; i++) tick();
    check("drain_empty", 64'(expq.size()), 64'd0);
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    in_x = 32'd0; in_y = 32'd0; in_cin = 1'b0;
    s64_in_valid = 1'b0; s64_x = 64'd0; s16_in_valid = 1'b0; s16_x = 16'd0;
    last_sum = 32'd0; prev_sum = 32'd0; last_cout = 1'b0; prev_cout = 1'b0;
    last_acc = 1'b0; prev_stall = 1'b0;
    @(negedge clock);

    // Reset state
    tick();
    tick();
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_sum", 64'(out_sum), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd0);
`ifdef CLA_PIPE_COUT_EN
    check("rst_out_cout", 64'(out_cout), 64'd0);
`endif
    reset = 1'b0;
    #1;
    check("post_rst_in_ready", 64'(in_ready), 64'd1);

    // Single beat 0xFF + 0x1, latency
    nout = 0;
    in_valid = 1'b1; in_x = 32'h0000_00FF; in_y = 32'h0000_0001; in_cin = 1'b0;
    tick();
    drain(20);
    check("single_sum", 64'(last_sum), 64'h100);
    check("single_latency", 64'(last_lat), 64'd4);
    check("single_count", 64'(nout), 64'd1);

    // Full propagate with wrap-around
    in_valid = 1'b1; in_x = 32'hFFFF_FFFF; in_y = 32'h0000_0000; in_cin = 1'b1;
    tick();
    drain(20);
    check("propagate_sum", 64'(last_sum), 64'd0);
`ifdef CLA_PIPE_COUT_EN
    check("propagate_cout", 64'(last_cout), 64'd1);
`endif

    // 16 back-to-back random beats
    nout = 0;
    for (int i = 0; i < 16; i++) begin
      in_valid = 1'b1; in_x = $urandom; in_y = $urandom; in_cin = 1'($urandom_range(0, 1));
      tick();
    end
    drain(40);
    check("b2b_count", 64'(nout), 64'd16);
    check("b2b_span", 64'(last_out_cyc - first_out_cyc), 64'd15);
    check("b2b_latency", 64'(last_lat), 64'd4);

    // Backpressure: out_ready pattern 1,0,0,1
    for (int i = 0; i < 8; i++) begin
      bx[i] = $urandom; by[i] = $urandom; bc[i] = 1'($urandom_range(0, 1));
    end
    nout = 0; sent = 0;
    for (int t = 0; t < 100 && (sent < 8 || expq.size() > 0); t++) begin
      out_ready = ((t % 4) == 0) || ((t % 4) == 3);
      in_valid = (sent < 8);
      if (sent < 8) begin
        in_x = bx[sent]; in_y = by[sent]; in_cin = bc[sent];
      end
      tick();
      if (last_acc) sent++;
    end
    check("bp_sent", 64'(sent), 64'd8);
    check("bp_count", 64'(nout), 64'd8);
    check("bp_empty", 64'(expq.size()), 64'd0);

    // Reset with three beats in flight
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_x = $urandom; in_y = $urandom; in_cin = 1'b0;
      tick();
    end
    reset = 1'b1; in_valid = 1'b0;
    tick();
    reset = 1'b0;
    #1;
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    nout = 0;
    in_valid = 1'b1; in_x = 32'h1; in_y = 32'h2; in_cin = 1'b0;
    tick();
    drain(20);
    for (int i = 0; i < 4; i++) tick();
    check("midrst_count", 64'(nout), 64'd1);
    check("midrst_sum", 64'(last_sum), 64'h3);

    // Parameter sweep: MSB + MSB wraps to zero
    s64_x = 64'h8000_0000_0000_0000; s64_in_valid = 1'b1;
    s16_x = 16'h8000; s16_in_valid = 1'b1;
    #1;
    check("s64_in_ready", 64'(s64_in_ready), 64'd1);
    check("s16_in_ready", 64'(s16_in_ready), 64'd1);
    @(posedge clock);
    @(negedge clock);
    s64_in_valid = 1'b0; s16_in_valid = 1'b0;
    lat64 = -1; lat16 = -1;
    for (int c = 1; c <= 10; c++) begin
      #1;
      if (s64_out_valid === 1'b1 && lat64 < 0) begin
        lat64 = c;
        check("s64_sum", s64_sum, 64'd0);
`ifdef CLA_PIPE_COUT_EN
        check("s64_cout", 64'(s64_out_cout), 64'd1);
`endif
      end
      if (s16_out_valid === 1'b1 && lat16 < 0) begin
        lat16 = c;
        check("s16_sum", 64'(s16_sum), 64'd0);
`ifdef CLA_PIPE_COUT_EN
        check("s16_cout", 64'(s16_out_cout), 64'd1);
`endif
      end
      @(posedge clock);
      @(negedge clock);
    end
    check("s64_latency", 64'(lat64), 64'd4);
    check("s16_latency", 64'(lat16), 64'd2);

    // Random valid/ready traffic
    nout = 0; sent = 0;
    for (int t = 0; t < 200; t++) begin
      in_valid = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      in_x = $urandom; in_y = $urandom; in_cin = 1'($urandom_range(0, 1));
      tick();
      if (last_acc) sent++;
    end
    drain(60);
    check("rand_count", 64'(nout), 64'(sent));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
